// File: rtl/golden_nonce_fifo.sv
// Buffers golden-nonce hits (nonce plus 256-bit hash) from the comparator and
// streams each one to the host bridge as nine 32-bit words, counting any hits lost to a full buffer.
module golden_nonce_fifo #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     cmp_valid,
    input  logic                     cmp_match,
    input  logic [31:0]              cmp_nonce,
    input  logic [255:0]             cmp_hash,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] LAST_WORD = 4'd8;

    // Entry layout: nonce in the top 32 bits, hash below it.
    logic [287:0]      mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [3:0]        word_idx_q, word_idx_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              push_req, handshake, pop, full, push_ok, drop;
    logic [287:0]      head;

    // out_valid/out_ready: a word transfers in any cycle where both are high;
    // the word and its out_last flag hold steady until that transfer happens.
    assign full      = (count_q == CW'(DEPTH));
    assign push_req  = cmp_valid & cmp_match & ~clear;
    assign handshake = (count_q != '0) & out_ready & ~clear;
    assign pop       = handshake & (word_idx_q == LAST_WORD);
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {cmp_nonce, cmp_hash};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            word_idx_d = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                word_idx_d = '0;
            end else if (handshake) begin
                word_idx_d = word_idx_q + 4'd1;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end
    end

    // Word 0 is the nonce; words 1..8 walk the hash from its most significant end.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_data = '0;
        out_last = 1'b0;
        if (count_q != '0) begin
            if (word_idx_q == 4'd0) begin
                out_data = head[287:256];
            end
            for (int k = 1; k <= 8; k++) begin
                if (word_idx_q == 4'(k)) begin
                    out_data = head[255-32*(k-1) -: 32];
                end
            end
            out_last = (word_idx_q == LAST_WORD);
        end
    end

    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Bench for golden_nonce_fifo: a reference model tracks occupancy and a queue of
// expected words, with directed scenarios followed by a random phase.
module tb_golden_nonce_fifo;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         cmp_valid = 1'b0;
  logic         cmp_match = 1'b0;
  logic [31:0]  cmp_nonce = '0;
  logic [255:0] cmp_hash = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
  logic [2:0]   count;
  logic         overflow;
  logic [DROP_W-1:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Each entry is {last, data}.
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];

  int          m_count = 0;
  logic [3:0]  m_word = '0;
  logic        m_ovf = 1'b0;
  logic [DROP_W-1:0] m_drop = '0;

  golden_nonce_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cmp_valid(cmp_valid), .cmp_match(cmp_match),
    .cmp_nonce(cmp_nonce), .cmp_hash(cmp_hash),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard and reference model, evaluated on the falling edge
  always @(negedge clk) begin
    logic hs, pop, push;
    logic [32:0] w;
    logic [255:0] sh;
    if (!rst_n) begin
      m_count = 0; m_word = '0; m_ovf = 1'b0; m_drop = '0;
      exp_q.delete();
    end else begin
      check_val("out_valid", out_valid, m_count != 0);
      check_val("count", count, m_count);
      check_val("overflow", overflow, m_ovf);
      check_val("drop_cnt", drop_cnt, m_drop);
      if (m_count == 0) begin
        check_val("idle_data", {out_last, out_data}, 0);
      end
      if (clear) begin
        m_count = 0; m_word = '0; m_ovf = 1'b0; m_drop = '0;
        exp_q.delete();
      end else begin
        hs   = (m_count != 0) && out_ready;
        pop  = hs && (m_word == 4'd8);
        push = cmp_valid && cmp_match;
        if (hs) begin
          check_val("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check_val("word", {out_last, out_data}, w);
          end
          rx_q.push_back({out_last, out_data});
          m_word = pop ? 4'd0 : m_word + 4'd1;
        end
        if (push && (m_count < DEPTH || pop)) begin
          exp_q.push_back({1'b0, cmp_nonce});
          for (int k = 1; k <= 8; k++) begin
            sh = cmp_hash >> (256 - 32 * k);
            exp_q.push_back({k == 8, sh[31:0]});
          end
          if (!pop) m_count++;
        end else begin
          if (push) begin
            m_ovf = 1'b1;
            if (m_drop != '1) m_drop++;
          end
          if (pop) m_count--;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] nonce, input logic [255:0] hash);
    cmp_valid = 1'b1; cmp_match = 1'b1; cmp_nonce = nonce; cmp_hash = hash;
    tick();
    cmp_valid = 1'b0; cmp_match = 1'b0;
  endtask

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (count == 0) break;
      tick();
    end
    check_val("drain_done", count, 0);
  endtask

  task automatic check_rx_nonce(input string tag, input int idx, input logic [31:0] exp);
    logic [32:0] e;
    e = (idx < rx_q.size()) ? rx_q[idx] : 33'h1_ffff_ffff;
    check_val(tag, e, {1'b0, exp});
  endtask

  logic [31:0] t1_words [9];
  int cycles;

  initial begin
    // reset state
    #2;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", {out_last, out_data}, 0);
    check_val("rst_count", count, 0);
    check_val("rst_flags", {overflow, drop_cnt}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // single hit, known words
    t1_words[0] = 32'h0000_1234;
    t1_words[1] = 32'h0000_0000;
    for (int i = 2; i < 8; i++) t1_words[i] = 32'hFFFF_FFFF;
    t1_words[8] = 32'hFFFF_0001;
    rx_q.delete();
    out_ready = 1'b1;
    hit(32'h0000_1234, {32'h0, {6{32'hFFFF_FFFF}}, 32'hFFFF_0001});
    check_val("t1_lat_valid", out_valid, 1);
    check_val("t1_lat_data", out_data, 32'h0000_1234);
    check_val("t1_count", count, 1);
    wait_drain(20);
    check_val("t1_nwords", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check_val("t1_word", rx_q[i], {i == 8, t1_words[i]});
    end

    // verdicts without a match are ignored
    cmp_valid = 1'b1; cmp_match = 1'b0; cmp_nonce = 32'hDEAD_0000;
    repeat (20) tick();
    cmp_valid = 1'b0;
    check_val("t2_valid", out_valid, 0);
    check_val("t2_count", count, 0);

    // overflow with six hits into four slots
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) hit(i, rand_hash());
    check_val("t3_count", count, 4);
    check_val("t3_ovf", overflow, 1);
    check_val("t3_drop", drop_cnt, 2);
    rx_q.delete();
    wait_drain(60);
    for (int i = 0; i < 4; i++) check_rx_nonce("t3_order", 9 * i, i + 1);
    check_val("t3_ovf_sticky", overflow, 1);

    // push coincident with the word-8 handshake of a full FIFO
    pulse_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) hit(32'h10 + i, rand_hash());
    rx_q.delete();
    out_ready = 1'b1;
    repeat (8) tick();
    check_val("t4_last", out_last, 1);
    hit(32'h99, rand_hash());
    check_val("t4_count", count, 4);
    check_val("t4_drop", drop_cnt, 0);
    wait_drain(60);
    check_val("t4_nwords", rx_q.size(), 45);
    check_rx_nonce("t4_tail", 36, 32'h99);
    check_val("t4_ovf", overflow, 0);

    // out_ready toggling stretches an entry to 18 cycles
    out_ready = 1'b0;
    hit(32'hABCD_0005, rand_hash());
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (count == 0) break;
      out_ready = cycles[0];
      tick();
      cycles++;
    end
    out_ready = 1'b0;
    check_val("t5_cycles", cycles, 18);

    // clear together with a push, with overflow set and three entries stored
    for (int i = 0; i < 5; i++) hit(32'h20 + i, rand_hash());
    out_ready = 1'b1;
    repeat (9) tick();
    out_ready = 1'b0;
    check_val("t6_count", count, 3);
    check_val("t6_ovf", overflow, 1);
    clear = 1'b1; cmp_valid = 1'b1; cmp_match = 1'b1; cmp_nonce = 32'h77;
    tick();
    clear = 1'b0; cmp_valid = 1'b0; cmp_match = 1'b0;
    check_val("t6_clr_count", count, 0);
    check_val("t6_clr_flags", {overflow, drop_cnt}, 0);
    check_val("t6_clr_valid", out_valid, 0);

    // asynchronous reset mid-entry
    hit(32'h55, rand_hash());
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_val("t7_valid", out_valid, 0);
    check_val("t7_data", {out_last, out_data}, 0);
    check_val("t7_count", count, 0);
    check_val("t7_flags", {overflow, drop_cnt}, 0);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cmp_valid = ($urandom_range(0, 2) == 0);
      cmp_match = $urandom_range(0, 1);
      cmp_nonce = $urandom;
      cmp_hash  = rand_hash();
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 80) == 0);
      tick();
    end
    cmp_valid = 1'b0; cmp_match = 1'b0; clear = 1'b0;
    wait_drain(100);
    tick();
    check_val("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
